compare_seq: RTL and testbench
==============================

# compare_seq

Multi-cycle magnitude comparator that generalises the 32-bit combinational less-than compare used by the ALU/branch path. Operand width and digit size are parameters, and mode is selectable per transaction: signed or unsigned. Operands are scanned MSB-first one digit per cycle with early termination. Operands enter and results leave through valid/ready handshakes, so the block can sit behind the decode stage for SLT/SLTU and branch-compare offload. Every case, including equality, produces a fully defined, registered result.

## Interface
- WIDTH, 32: operand width in bits; must be ≥ 2.
- DIGIT, 4: bits compared per cycle; must divide WIDTH. NDIG = WIDTH/DIGIT.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  left operand.
- b  in  WIDTH  right operand.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- lt  out  1  a < b.
- eq  out  1  a == b.
- gt  out  1  a > b.
- out_data  out  32  SLT-style result: 32'h1 when lt, else 32'h0.

## Operation
- **States:** IDLE, SCAN, DONE. Reset state is IDLE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready, capture a and b into operand registers.
  - When is_signed = 1, invert bit WIDTH-1 of both captured operands. An unsigned compare of the biased values then equals a signed compare.
  - Load digit counter with NDIG-1, clear lt/eq/gt/out_data, and go to SCAN.
- **SCAN**
  - Each cycle compares captured digit [cnt*DIGIT +: DIGIT] of a against the same digit of b, as unsigned values.
  - If the digit of a is greater: set gt and go to DONE.
  - If the digit of a is less: set lt, set out_data = 1, and go to DONE.
  - If the digits are equal and cnt == 0: set eq and go to DONE.
  - If the digits are equal and cnt > 0: decrement cnt and stay in SCAN.
- **DONE**
  - out_valid = 1. lt/eq/gt/out_data stay stable.
  - On out_ready, go to IDLE. out_valid drops the next cycle.
- **Result encoding:** exactly one of lt/eq/gt is high whenever out_valid = 1. All three are 0 in IDLE and SCAN.
- **Ignored inputs:** in_valid outside IDLE is ignored; no queuing. Changes on a/b/is_signed after capture have no effect.
- **Counter:** cnt width is clog2(NDIG), minimum 1. No wrap-around; cnt never decrements below 0.
- **DIGIT = WIDTH:** NDIG = 1, and every compare finishes in one SCAN cycle.

## Timing
- **Reset values:** in_ready = 1 (IDLE); out_valid, lt, eq, gt = 0; out_data = 32'h0.
- **Reset during SCAN or DONE:** the in-flight transaction is discarded and nothing is emitted.
- **Latency:** capture at edge E. Let j be the number of digits examined, 1..NDIG. out_valid is first high in the cycle after edge E+j, so latency is j+1 cycles.
  - Minimum is 2 cycles.
  - Maximum is NDIG+1 cycles; 9 with the default parameters. This covers both equality and a difference only in digit 0.
- **Throughput:** the next capture is possible in the cycle after the out_valid & out_ready handshake, since IDLE is re-entered there.
- **Back-pressure:** with out_ready held low, the block stays in DONE indefinitely with outputs constant and in_ready = 0.
- **Combinational paths:** all outputs are registered or decoded from state only. There is no path from in_valid or out_ready to any output.

## Test plan
All scenarios use WIDTH=32, DIGIT=4.
1. **Unsigned, top-digit difference:** a=32'h0000_0001, b=32'h8000_0000, is_signed=0 → out_valid 2 cycles after capture; lt=1, out_data=32'h1, eq=gt=0.
2. **Signed vs unsigned:** a=32'hFFFF_FFFF, b=32'h0000_0001.
   - With is_signed=1 → lt=1, out_data=1, latency 2.
   - Repeated with is_signed=0 → gt=1, out_data=0.
3. **Equality, worst case:** a=b=32'h1234_5678 → eq=1, lt=gt=0, out_data=0, out_valid at exactly 9 cycles. Repeat with a=32'h10, b=32'h11 → lt=1, also at 9 cycles.
4. **Signed negative pair:** a=32'h8000_0000, b=32'hFFFF_FFFF, is_signed=1 → lt=1. With a and b swapped → gt=1.
5. **Back-pressure:**
   - Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands → outputs unchanged, in_ready=0, new operands not captured.
   - Raise out_ready → out_valid low next cycle and in_ready=1.
   - A back-to-back capture then succeeds.
6. **Reset mid-scan:** assert rst 3 cycles into a worst-case compare → outputs go to reset values immediately. After release, a fresh a=5, b=3 unsigned compare gives gt=1 with no stale result.

Source files
------------

// File: rtl/compare_seq.sv
// compare_seq: multi-cycle magnitude comparator for SLT/SLTU and branch-compare
// offload. Operands are scanned MSB-first, one DIGIT-bit slice per cycle, and
// the scan stops at the first differing digit. Signed compares reuse the
// unsigned datapath by flipping the sign bit of both operands at capture.
//
// Handshakes (both ports): a transfer happens on a rising edge where valid and
// ready are both high. in_ready is high only in IDLE. out_valid is high only in
// DONE and, together with the result, is held until out_ready is seen. No
// output depends combinationally on in_valid or out_ready.
module compare_seq #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             lt,
    output logic             eq,
    output logic             gt,
    output logic [31:0]      out_data
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] a_r, b_r;
    logic [CW-1:0]    cnt;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic             lt_r, eq_r, gt_r;
    logic [31:0]      out_data_r;

    // Select the digit addressed by cnt from both captured operands.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) begin
                a_dig = a_r[i*DIGIT +: DIGIT];
                b_dig = b_r[i*DIGIT +: DIGIT];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next-state logic: scan ends on a differing digit or after digit 0.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = SCAN;
            SCAN:    if ((a_dig != b_dig) || (cnt == '0)) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath: operand capture, digit counter and registered result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r        <= '0;
            b_r        <= '0;
            cnt        <= '0;
            lt_r       <= 1'b0;
            eq_r       <= 1'b0;
            gt_r       <= 1'b0;
            out_data_r <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Biasing the sign bit maps two's-complement order onto unsigned order.
                        a_r        <= is_signed ? (a ^ SIGN_BIT) : a;
                        b_r        <= is_signed ? (b ^ SIGN_BIT) : b;
                        cnt        <= CW'(NDIG - 1);
                        lt_r       <= 1'b0;
                        eq_r       <= 1'b0;
                        gt_r       <= 1'b0;
                        out_data_r <= 32'h0;
                    end
                end
                SCAN: begin
                    if (a_dig > b_dig) begin
                        gt_r <= 1'b1;
                    end else if (a_dig < b_dig) begin
                        lt_r       <= 1'b1;
                        out_data_r <= 32'h1;
                    end else if (cnt == '0) begin
                        eq_r <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    // Flags return to zero once the result has been taken.
                    if (out_ready) begin
                        lt_r       <= 1'b0;
                        eq_r       <= 1'b0;
                        gt_r       <= 1'b0;
                        out_data_r <= 32'h0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign lt        = lt_r;
    assign eq        = eq_r;
    assign gt        = gt_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_compare_seq.sv
// Bench for compare_seq (WIDTH=32, DIGIT=4): fixed vector table, random
// vectors checked against a reference model, back-pressure and reset-mid-scan
// sequences. Expected results travel through a scoreboard queue.
module tb_compare_seq;

  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;
  localparam int W     = 43;  // {latency[7:0], lt, eq, gt, out_data[31:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid, in_ready, is_signed;
  logic [WIDTH-1:0] a_i, b_i;
  logic             out_valid, out_ready;
  logic             lt, eq, gt;
  logic [31:0]      out_data;

  compare_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a_i),
    .b        (b_i),
    .is_signed(is_signed),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .lt       (lt),
    .eq       (eq),
    .gt       (gt),
    .out_data (out_data)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [2:0]  res;  // {lt, eq, gt}
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input int lat, input logic [2:0] res);
    logic [7:0] l8;
    l8 = 8'(lat);
    return {l8, res, (res[2] ? 32'h1 : 32'h0)};
  endfunction

  // Reference model: direct signed/unsigned compare; latency from the count
  // of leading equal digits (sign-bit bias never changes digit equality).
  function automatic logic [W-1:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic ml, me, mg;
    int j;
    ml = s ? ($signed(a) < $signed(b)) : (a < b);
    me = (a == b);
    mg = !ml && !me;
    j = 1;
    for (int k = NDIG - 1; k > 0; k--) begin
      if (a[k*DIGIT +: DIGIT] != b[k*DIGIT +: DIGIT]) break;
      j++;
    end
    return pack(j + 1, {ml, me, mg});
  endfunction

  // ---------------- driver tasks ----------------
  // Offer one operand pair; returns after the capture edge (+1).
  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [W-1:0] e);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(posedge clk); #1; t++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    a_i = a; b_i = b; is_signed = s; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result (latency counted with the capture edge as cycle 1),
  // pop the expected entry and compare every field.
  task automatic collect(input string name);
    int lat;
    logic [W-1:0] e;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
    check({name, "_valid"}, {63'd0, out_valid}, 64'd1);
    if (exp_q.size() == 0) begin
      check({name, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_lat"}, 64'(lat), 64'(e[42:35]));
      check({name, "_lt"},  {63'd0, lt}, {63'd0, e[34]});
      check({name, "_eq"},  {63'd0, eq}, {63'd0, e[33]});
      check({name, "_gt"},  {63'd0, gt}, {63'd0, e[32]});
      check({name, "_data"}, {32'd0, out_data}, {32'd0, e[31:0]});
    end
  endtask

  task automatic accept(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_drop"},  {63'd0, out_valid}, 64'd0);
    check({name, "_ready"}, {63'd0, in_ready}, 64'd1);
    check({name, "_clr"},   {61'd0, lt, eq, gt}, 64'd0);
  endtask

  task automatic run_txn(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [W-1:0] e, input logic do_accept);
    drive(a, b, s, e);
    collect(name);
    if (do_accept) accept(name);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{32'h0000_0001, 32'h8000_0000, 1'b0, 3'b100, 2};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3'b100, 2};
    vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 3'b001, 2};
    vecs[3] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 3'b010, 9};
    vecs[4] = '{32'h0000_0010, 32'h0000_0011, 1'b0, 3'b100, 9};
    vecs[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 3'b100, 2};
    vecs[6] = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 3'b001, 2};
    vecs[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 3'b001, 2};
    vecs[8] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 3'b010, 9};
    vecs[9] = '{32'h1234_5600, 32'h1234_5700, 1'b1, 3'b100, 7};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_i = '0; b_i = '0; is_signed = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_flags",     {61'd0, lt, eq, gt}, 64'd0);
    check("rst_data",      {32'd0, out_data}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Fixed vectors.
    for (int i = 0; i < 10; i++)
      run_txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
              pack(vecs[i].lat, vecs[i].res), 1'b1);

    // Random vectors with shared high-order prefixes to vary latency.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] ra, rb, mask;
      logic rs;
      ra   = $urandom;
      mask = 32'hFFFF_FFFF >> $urandom_range(0, 31);
      rb   = ($urandom_range(0, 3) == 0) ? ra : (ra ^ ($urandom & mask));
      rs   = 1'($urandom_range(0, 1));
      run_txn($sformatf("rnd%0d", i), ra, rb, rs, model(ra, rb, rs), 1'b1);
    end

    // Back-pressure: result held, new operands ignored.
    run_txn("bp", 32'h1, 32'h2, 1'b0, pack(9, 3'b100), 1'b0);
    for (int i = 0; i < 5; i++) begin
      a_i = $urandom; b_i = $urandom; is_signed = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check($sformatf("bp_hold_valid%0d", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("bp_hold_ready%0d", i), {63'd0, in_ready}, 64'd0);
      check($sformatf("bp_hold_res%0d", i), {29'd0, lt, eq, gt, out_data}, {29'd0, 3'b100, 32'h1});
    end
    accept("bp");
    // Back-to-back capture straight after the handshake.
    run_txn("b2b", 32'h3, 32'h3, 1'b0, pack(9, 3'b010), 1'b1);

    // Reset three cycles into a worst-case compare.
    a_i = 32'h1234_5678; b_i = 32'h1234_5678; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_flags", {61'd0, lt, eq, gt}, 64'd0);
    check("midrst_data",  {32'd0, out_data}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      check("midrst_no_emit", {63'd0, out_valid}, 64'd0);
    end
    run_txn("post_rst", 32'd5, 32'd3, 1'b0, pack(9, 3'b001), 1'b1);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
